writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/mycpu_pkg.sv | 78 +++++++
 rtl/writeback_stage_if.sv | 44 ++++
 rtl/regfile_2r1w.sv | 62 ++++++
 rtl/writeback_stage.sv | 148 ++++++++++++++
 tb/tb_writeback_stage.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mycpu_pkg.sv
// mycpu_pkg
// Shared CPU types used by the pipeline stages:
//   creg_addr_t  - architectural register index (r0..r31)
//   op_t         - decoded opcode
//   src_t        - where a register write takes its value from
//   write_reg_t  - decoded write descriptor (valid, src, value, dst)
// load_extract() turns a raw load word into the architectural result, so the
// memory stage and the writeback stage agree on the byte/halfword rules.
package mycpu_pkg;

    typedef logic [4:0] creg_addr_t;

    typedef enum logic [4:0] {
        OP_NOP,
        OP_ADDU,
        OP_SUBU,
        OP_AND,
        OP_OR,
        OP_SLT,
        OP_LUI,
        OP_LB,
        OP_LBU,
        OP_LH,
        OP_LHU,
        OP_LW,
        OP_SB,
        OP_SH,
        OP_SW,
        OP_BEQ,
        OP_BNE,
        OP_J,
        OP_JAL,
        OP_MULT,
        OP_DIV,
        OP_MFHI,
        OP_MFLO,
        OP_MTC0,
        OP_MFC0
    } op_t;

    typedef enum logic [1:0] {
        SRC_NOP = 2'd0,
        SRC_ALU = 2'd1,
        SRC_MEM = 2'd2
    } src_t;

    typedef struct packed {
        logic       valid;
        src_t       src;
        logic [31:0] value;
        creg_addr_t dst;
    } write_reg_t;

    // Byte loads pick lane addr_lo; halfword loads pick half addr_lo[1] and
    // ignore addr_lo[0]. Anything that is not a sub-word load returns the word.
    function automatic logic [31:0] load_extract(op_t op, logic [1:0] addr_lo,
                                                 logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (addr_lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if
// Bundle between the upstream pipeline (memory stage) and the writeback stage.
//   in_valid / in_ready  - upstream handshake
//   in_op                - decoded opcode
//   in_write_reg         - write descriptor (valid, src, value, dst)
//   in_alu_result        - ALU result for SRC_ALU writes
//   in_addr_lo           - low two bits of the load address
//   mem_rvalid/mem_rdata - load response, a single-cycle pulse
// Modports: master = producer side, slave = writeback stage.
interface writeback_stage_if;
    import mycpu_pkg::*;

    logic        in_valid;
    logic        in_ready;
    op_t         in_op;
    write_reg_t  in_write_reg;
    logic [31:0] in_alu_result;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output in_valid,
        output in_op,
        output in_write_reg,
        output in_alu_result,
        output in_addr_lo,
        output mem_rvalid,
        output mem_rdata,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_op,
        input  in_write_reg,
        input  in_alu_result,
        input  in_addr_lo,
        input  mem_rvalid,
        input  mem_rdata,
        output in_ready
    );

endinterface

// File: rtl/regfile_2r1w.sv
// regfile_2r1w
// 32 x 32-bit register file, two combinational read ports, one write port
// that updates on the rising clock edge. r0 always reads zero and is never
// stored. Synchronous active-low reset loads r1..r31 with REG_RESET_VALUE.
//   clk, resetn  - clock and synchronous active-low reset
//   ra1/ra2      - read addresses, rd1/rd2 - read data
//   we, wa, wd   - write enable, address and data
// Build option WB_BYPASS_EN: a read of the register being written this cycle
// returns the write data (write-through). Without it the read returns the
// stored value until the next cycle.
module regfile_2r1w
    import mycpu_pkg::*;
#(
    parameter logic [31:0] REG_RESET_VALUE = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  creg_addr_t  ra1,
    input  creg_addr_t  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  creg_addr_t  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != '0)) begin
            regs_d[wa] = wd;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            regs_q[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= REG_RESET_VALUE;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
        rd2 = (ra2 == '0) ? '0 : regs_q[ra2];
`ifdef WB_BYPASS_EN
        if (we && (ra1 != '0) && (ra1 == wa)) begin
            rd1 = wd;
        end
        if (we && (ra2 != '0) && (ra2 == wa)) begin
            rd2 = wd;
        end
`endif
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage
// Final pipeline stage: holds one instruction, waits for its load data when
// needed, and commits the result into the register file for one cycle.
//   clk, resetn        - clock, synchronous active-low reset
//   up (slave)         - upstream handshake, decoded entry and load response
//   ra1/ra2, rd1/rd2   - combinational register read ports for decode
//   wb_valid/dst/value - commit trace, valid only in a writing COMMIT cycle
//   pend_valid/dst     - destination still in flight (hazard hint to decode)
// Parameter REG_RESET_VALUE: reset value of r1..r31.
// Build option WB_BYPASS_EN: reads of wb_dst during COMMIT see wb_value.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// EMPTY    | no entry held, ready for a new one
// WAIT_MEM | load accepted, waiting for mem_rvalid; upstream stalled
// COMMIT   | result known, written at the end of this cycle; a new entry
//          | may be accepted in the same cycle
module writeback_stage
    import mycpu_pkg::*;
#(
    parameter logic [31:0] REG_RESET_VALUE = 32'h0
) (
    input  logic               clk,
    input  logic               resetn,
    writeback_stage_if.slave   up,
    input  creg_addr_t         ra1,
    input  creg_addr_t         ra2,
    output logic [31:0]        rd1,
    output logic [31:0]        rd2,
    output logic               wb_valid,
    output creg_addr_t         wb_dst,
    output logic [31:0]        wb_value,
    output logic               pend_valid,
    output creg_addr_t         pend_dst
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_WAIT_MEM,
        ST_COMMIT
    } wb_state_t;

    wb_state_t   state_q,   state_d;
    op_t         op_q,      op_d;
    write_reg_t  wr_q,      wr_d;
    logic [31:0] alu_q,     alu_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] rdata_q,   rdata_d;

    logic        in_ready_int;
    logic        accept;
    logic        writes_reg;
    logic [31:0] commit_value;

    // Reset forces the handshake low regardless of the held state.
    assign in_ready_int = resetn && (state_q != ST_WAIT_MEM);
    assign up.in_ready  = in_ready_int;
    assign accept       = up.in_valid && in_ready_int;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wr_d      = wr_q;
        alu_d     = alu_q;
        addr_lo_d = addr_lo_q;
        rdata_d   = rdata_q;
        if (accept) begin
            op_d      = up.in_op;
            wr_d      = up.in_write_reg;
            alu_d     = up.in_alu_result;
            addr_lo_d = up.in_addr_lo;
            if (up.in_write_reg.src == SRC_MEM) begin
                // A response arriving together with the accept is taken
                // immediately, so the load skips WAIT_MEM entirely.
                if (up.mem_rvalid) begin
                    rdata_d = up.mem_rdata;
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_WAIT_MEM;
                end
            end else begin
                state_d = ST_COMMIT;
            end
        end else begin
            unique case (state_q)
                ST_WAIT_MEM: begin
                    if (up.mem_rvalid) begin
                        rdata_d = up.mem_rdata;
                        state_d = ST_COMMIT;
                    end
                end
                ST_COMMIT: state_d = ST_EMPTY;
                default:   state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_EMPTY;
            op_q      <= OP_NOP;
            wr_q      <= '0;
            alu_q     <= '0;
            addr_lo_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wr_q      <= wr_d;
            alu_q     <= alu_d;
            addr_lo_q <= addr_lo_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        unique case (wr_q.src)
            SRC_ALU: commit_value = alu_q;
            SRC_MEM: commit_value = load_extract(op_q, addr_lo_q, rdata_q);
            default: commit_value = wr_q.value;
        endcase
    end

    // r0 is architecturally constant, so a write to it is not a write at all.
    assign writes_reg = wr_q.valid && (wr_q.dst != '0);

    assign wb_valid   = resetn && (state_q == ST_COMMIT) && writes_reg;
    assign wb_dst     = wb_valid ? wr_q.dst : '0;
    assign wb_value   = wb_valid ? commit_value : '0;

    assign pend_valid = resetn && (state_q != ST_EMPTY) && writes_reg;
    assign pend_dst   = pend_valid ? wr_q.dst : '0;

    regfile_2r1w #(
        .REG_RESET_VALUE (REG_RESET_VALUE)
    ) u_regfile (
        .clk    (clk),
        .resetn (resetn),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .we     (wb_valid),
        .wa     (wb_dst),
        .wd     (wb_value)
    );

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage
// Directed scenarios with literal expectations, then randomized traffic
// (including random resets and stray load responses) checked every cycle
// against a transaction-level model of the stage and its register file.
module tb_writeback_stage;
    import mycpu_pkg::*;

    localparam logic [31:0] RST_VAL = 32'hC0DE_0001;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    writeback_stage_if u_if();

    creg_addr_t  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        wb_valid;
    creg_addr_t  wb_dst;
    logic [31:0] wb_value;
    logic        pend_valid;
    creg_addr_t  pend_dst;

    writeback_stage #(.REG_RESET_VALUE(RST_VAL)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .up         (u_if),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .wb_valid   (wb_valid),
        .wb_dst     (wb_dst),
        .wb_value   (wb_value),
        .pend_valid (pend_valid),
        .pend_dst   (pend_dst)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One in-flight instruction: present, whether its result is known yet,
    // whether it writes, where, and the final value.
    logic [31:0] m_regs [32];
    bit          m_present, m_has_data, m_wv;
    creg_addr_t  m_dst;
    logic [31:0] m_val;
    op_t         m_op;
    logic [1:0]  m_lo;

    function automatic logic [31:0] m_load(input op_t op, input logic [1:0] lo, input logic [31:0] d);
        int b, h;
        b = int'((d >> (8 * int'(lo))) & 32'hFF);
        h = int'((d >> (16 * int'(lo[1]))) & 32'hFFFF);
        case (op)
            OP_LB:   return (b >= 128)   ? 32'(b - 256)   : 32'(b);
            OP_LBU:  return 32'(b);
            OP_LH:   return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            OP_LHU:  return 32'(h);
            default: return d;
        endcase
    endfunction

    task automatic model_step();
        bit ready;
        if (!resetn) begin
            m_present = 0; m_has_data = 0; m_wv = 0; m_dst = '0; m_val = '0;
            m_regs[0] = '0;
            for (int i = 1; i < 32; i++) m_regs[i] = RST_VAL;
            return;
        end
        if (m_present && m_has_data && m_wv && m_dst != 0) m_regs[m_dst] = m_val;
        ready = !(m_present && !m_has_data);
        if (u_if.in_valid && ready) begin
            m_present = 1;
            m_wv  = u_if.in_write_reg.valid;
            m_dst = u_if.in_write_reg.dst;
            m_op  = u_if.in_op;
            m_lo  = u_if.in_addr_lo;
            case (u_if.in_write_reg.src)
                SRC_ALU: begin m_val = u_if.in_alu_result; m_has_data = 1; end
                SRC_MEM: begin
                    m_has_data = u_if.mem_rvalid;
                    m_val = u_if.mem_rvalid ? m_load(m_op, m_lo, u_if.mem_rdata) : '0;
                end
                default: begin m_val = u_if.in_write_reg.value; m_has_data = 1; end
            endcase
        end else if (m_present && !m_has_data) begin
            if (u_if.mem_rvalid) begin
                m_has_data = 1;
                m_val = m_load(m_op, m_lo, u_if.mem_rdata);
            end
        end else begin
            m_present = 0;
        end
    endtask

    function automatic logic [31:0] m_read(input creg_addr_t a, input bit commit);
        if (a == 0) return '0;
        if (BYP && commit && a == m_dst) return m_val;
        return m_regs[a];
    endfunction

    // ---------------- per-cycle compare ----------------
    bit e_commit, e_pend;
    always @(negedge clk) begin
        if (check_en) begin
            e_commit = resetn && m_present && m_has_data && m_wv && (m_dst != 0);
            e_pend   = resetn && m_present && m_wv && (m_dst != 0);
            chk("in_ready",   32'(u_if.in_ready), 32'(resetn && !(m_present && !m_has_data)));
            chk("wb_valid",   32'(wb_valid),   32'(e_commit));
            chk("wb_dst",     32'(wb_dst),     e_commit ? 32'(m_dst) : 32'h0);
            chk("wb_value",   wb_value,        e_commit ? m_val : 32'h0);
            chk("pend_valid", 32'(pend_valid), 32'(e_pend));
            chk("pend_dst",   32'(pend_dst),   e_pend ? 32'(m_dst) : 32'h0);
            chk("rd1",        rd1,             m_read(ra1, e_commit));
            chk("rd2",        rd2,             m_read(ra2, e_commit));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        u_if.in_valid      = 1'b0;
        u_if.in_op         = OP_NOP;
        u_if.in_write_reg  = '0;
        u_if.in_alu_result = '0;
        u_if.in_addr_lo    = '0;
        u_if.mem_rvalid    = 1'b0;
        u_if.mem_rdata     = '0;
    endtask

    task automatic drive(input op_t op, input bit v, input src_t s, input logic [31:0] val,
                         input creg_addr_t d, input logic [31:0] alu, input logic [1:0] lo);
        write_reg_t w;
        w.valid = v; w.src = s; w.value = val; w.dst = d;
        u_if.in_valid      = 1'b1;
        u_if.in_op         = op;
        u_if.in_write_reg  = w;
        u_if.in_alu_result = alu;
        u_if.in_addr_lo    = lo;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        idle();
        ra1 = '0; ra2 = '0;
        resetn = 1'b0;

        // reset state
        tick();
        check_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(u_if.in_ready), 32'h0);
        chk("rst_pend_valid", 32'(pend_valid), 32'h0);
        tick();
        resetn = 1'b1; ra1 = 5'd7; ra2 = 5'd0;
        @(negedge clk);
        chk("post_rst_ready", 32'(u_if.in_ready), 32'h1);
        chk("post_rst_r7", rd1, RST_VAL);
        chk("post_rst_r0", rd2, 32'h0);
        chk("model_lb_pin", m_load(OP_LB, 2'd3, 32'h80FF_FF7F), 32'hFFFF_FF80);
        tick();

        // ADDU r5 = 0x1234
        drive(OP_ADDU, 1, SRC_ALU, 32'h0, 5'd5, 32'h1234, 2'd0);
        tick();
        idle(); ra1 = 5'd5;
        @(negedge clk);
        chk("addu_wb_valid", 32'(wb_valid), 32'h1);
        chk("addu_wb_dst", 32'(wb_dst), 32'h5);
        chk("addu_wb_value", wb_value, 32'h1234);
        chk("addu_rd1_commit", rd1, BYP ? 32'h1234 : RST_VAL);
        tick();
        @(negedge clk);
        chk("addu_rd1_after", rd1, 32'h1234);
        chk("addu_wb_clear", 32'(wb_valid), 32'h0);

        // LB r9, addr_lo=3, response three cycles after accept
        drive(OP_LB, 1, SRC_MEM, 32'h0, 5'd9, 32'h0, 2'd3);
        tick();
        idle();
        @(negedge clk); chk("lb_stall1", 32'(u_if.in_ready), 32'h0);
        chk("lb_pend_dst", 32'(pend_dst), 32'h9);
        tick();
        @(negedge clk); chk("lb_stall2", 32'(u_if.in_ready), 32'h0);
        tick();
        u_if.mem_rvalid = 1'b1; u_if.mem_rdata = 32'h80FF_FF7F;
        @(negedge clk); chk("lb_stall3", 32'(u_if.in_ready), 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("lb_wb_valid", 32'(wb_valid), 32'h1);
        chk("lb_wb_value", wb_value, 32'hFFFF_FF80);
        chk("lb_ready_again", 32'(u_if.in_ready), 32'h1);
        tick();

        // LHU r10, addr_lo=2, response with the accept
        drive(OP_LHU, 1, SRC_MEM, 32'h0, 5'd10, 32'h0, 2'd2);
        u_if.mem_rvalid = 1'b1; u_if.mem_rdata = 32'hBEEF_0000;
        tick();
        idle();
        @(negedge clk);
        chk("lhu_wb_valid", 32'(wb_valid), 32'h1);
        chk("lhu_wb_value", wb_value, 32'h0000_BEEF);
        chk("lhu_no_wait", 32'(u_if.in_ready), 32'h1);
        tick();

        // MTC0-style SRC_NOP to r0
        drive(OP_MTC0, 1, SRC_NOP, 32'hDEAD, 5'd0, 32'h0, 2'd0);
        tick();
        idle(); ra1 = 5'd0;
        @(negedge clk);
        chk("mtc0_wb_valid", 32'(wb_valid), 32'h0);
        chk("mtc0_pend_valid", 32'(pend_valid), 32'h0);
        chk("mtc0_r0", rd1, 32'h0);
        tick();

        // back-to-back ADDU r3=1, r3=2
        ra1 = 5'd3;
        drive(OP_ADDU, 1, SRC_ALU, 32'h0, 5'd3, 32'h1, 2'd0);
        @(negedge clk); chk("b2b_rd1_a", rd1, RST_VAL);
        tick();
        drive(OP_ADDU, 1, SRC_ALU, 32'h0, 5'd3, 32'h2, 2'd0);
        @(negedge clk); chk("b2b_rd1_b", rd1, BYP ? 32'h1 : RST_VAL);
        chk("b2b_ready", 32'(u_if.in_ready), 32'h1);
        tick();
        idle();
        @(negedge clk); chk("b2b_rd1_c", rd1, BYP ? 32'h2 : 32'h1);
        tick();
        @(negedge clk); chk("b2b_rd1_final", rd1, 32'h2);

        // reset during WAIT_MEM of LW r7 (r7 first set to 0x77)
        drive(OP_ADDU, 1, SRC_ALU, 32'h0, 5'd7, 32'h77, 2'd0);
        tick();
        idle(); ra1 = 5'd7;
        tick();
        drive(OP_LW, 1, SRC_MEM, 32'h0, 5'd7, 32'h0, 2'd0);
        tick();
        idle();
        @(negedge clk);
        chk("lw_pend_valid", 32'(pend_valid), 32'h1);
        chk("lw_r7_before", rd1, 32'h77);
        tick();
        resetn = 1'b0;
        @(negedge clk);
        chk("lw_rst_ready", 32'(u_if.in_ready), 32'h0);
        chk("lw_rst_pend", 32'(pend_valid), 32'h0);
        tick();
        resetn = 1'b1;
        u_if.mem_rvalid = 1'b1; u_if.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("lw_rst_r7", rd1, RST_VAL);
        chk("lw_rst_empty", 32'(u_if.in_ready), 32'h1);
        tick();
        idle();
        @(negedge clk);
        chk("lw_stale_ignored", 32'(wb_valid), 32'h0);
        chk("lw_r7_final", rd1, RST_VAL);
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            resetn = ($urandom_range(0, 199) != 0);
            ra1 = 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            u_if.mem_rvalid = ($urandom_range(0, 3) == 0);
            u_if.mem_rdata  = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                k = int'($urandom_range(0, 9));
                if (k <= 2)
                    drive((k == 0) ? OP_ADDU : (k == 1) ? OP_SUBU : OP_OR, 1, SRC_ALU, $urandom(),
                          5'($urandom_range(0, 7)), $urandom(), 2'($urandom_range(0, 3)));
                else if (k <= 6)
                    drive((k == 3) ? OP_LB : (k == 4) ? OP_LBU : (k == 5) ? OP_LH :
                          ($urandom_range(0, 1) == 0) ? OP_LHU : OP_LW, 1, SRC_MEM, $urandom(),
                          5'($urandom_range(0, 7)), $urandom(), 2'($urandom_range(0, 3)));
                else if (k == 7)
                    drive(OP_MTC0, 1, SRC_NOP, $urandom(), 5'($urandom_range(0, 7)), $urandom(),
                          2'($urandom_range(0, 3)));
                else if (k == 8)
                    drive(OP_SW, 0, SRC_NOP, $urandom(), 5'($urandom_range(0, 7)), $urandom(),
                          2'($urandom_range(0, 3)));
                else
                    drive(OP_MULT, 0, SRC_ALU, $urandom(), 5'($urandom_range(0, 7)), $urandom(),
                          2'($urandom_range(0, 3)));
            end else begin
                u_if.in_valid = 1'b0;
            end
            tick();
        end

        idle();
        resetn = 1'b1;
        tick();
        @(negedge clk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
